// File: rtl/uram_arb_pkg.sv
// Shared definitions for the uram arbiter: FSM state encoding and master IDs.
package uram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/uram_arb_pick.sv
// Two-way picker: chooses one winner among the eligible masters using
// round-robin against rr_last, or fixed M0 priority.
module uram_arb_pick
   import uram_arb_pkg::*;
#(
   parameter int PRIO_FIXED = 0
)(
   input  logic [1:0] eligible,
   input  logic       rr_last,
   output logic       winner,
   output logic       any
);

   // Resolve the winner; on a tie the master that did not win last goes first
   always_comb begin
      winner = M0;
      any    = |eligible;
      case (eligible)
         2'b01:   winner = M0;
         2'b10:   winner = M1;
         2'b11:   winner = (PRIO_FIXED != 0) ? M0 : ~rr_last;
         default: winner = M0;
      endcase
   end

endmodule

// File: rtl/uram_arbiter.sv
// Shares one uram between instruction fetch (M0) and data (M1), one access
// per cycle, with bus lock for atomic sequences and tagged read return.
module uram_arbiter
   import uram_arb_pkg::*;
#(
   parameter int READ_DELAY = 1,
   parameter int PRIO_FIXED = 0
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        ram_cs,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   arb_state_e  state_r;
   arb_state_e  state_nxt_s;
   logic        rr_last_r;
   logic        pend_v_r;
   logic        pend_id_r;
   logic [1:0]  eligible_s;
   logic        winner_s;
   logic        any_s;
   logic        grant_s;
   logic        win_we_s;
   logic        win_lock_s;
   logic [31:0] win_addr_s;
   logic [31:0] win_wdata_s;

   // Restrict competition to the lock owner while a lock is held
   always_comb begin
      eligible_s = 2'b00;
      case (state_r)
         ST_IDLE:  eligible_s = {m1_req, m0_req};
         ST_LOCK0: eligible_s = {1'b0, m0_req};
         ST_LOCK1: eligible_s = {m1_req, 1'b0};
         default:  eligible_s = 2'b00;
      endcase
   end

   uram_arb_pick #(
      .PRIO_FIXED (PRIO_FIXED)
   ) u_pick (
      .eligible (eligible_s),
      .rr_last  (rr_last_r),
      .winner   (winner_s),
      .any      (any_s)
   );

   // Reset holds the uram and both grants idle even while requests are high
   assign grant_s = any_s & rst_n;

   // Select the winning master's request fields
   always_comb begin
      if (winner_s == M1) begin
         win_we_s    = m1_we;
         win_lock_s  = m1_lock;
         win_addr_s  = m1_addr;
         win_wdata_s = m1_wdata;
      end else begin
         win_we_s    = m0_we;
         win_lock_s  = m0_lock;
         win_addr_s  = m0_addr;
         win_wdata_s = m0_wdata;
      end
   end

   assign m0_gnt    = grant_s & (winner_s == M0);
   assign m1_gnt    = grant_s & (winner_s == M1);
   assign ram_cs    = grant_s;
   assign ram_we    = grant_s & win_we_s;
   assign ram_addr  = grant_s ? win_addr_s  : 32'd0;
   assign ram_wdata = grant_s ? win_wdata_s : 32'd0;

   // Lock FSM: enter on a locked grant, leave on any edge the owner drops lock
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s && win_lock_s) begin
               state_nxt_s = (winner_s == M1) ? ST_LOCK1 : ST_LOCK0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOCK0: begin
            if (!m0_lock) state_nxt_s = ST_IDLE;
            else          state_nxt_s = ST_LOCK0;
         end
         ST_LOCK1: begin
            if (!m1_lock) state_nxt_s = ST_IDLE;
            else          state_nxt_s = ST_LOCK1;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, round-robin history and pending-read tag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         rr_last_r <= M1;
         pend_v_r  <= 1'b0;
         pend_id_r <= M0;
      end else begin
         state_r  <= state_nxt_s;
         pend_v_r <= (READ_DELAY != 0) && grant_s && !win_we_s;
         if (grant_s) begin
            rr_last_r <= winner_s;
            pend_id_r <= winner_s;
         end else begin
            rr_last_r <= rr_last_r;
            pend_id_r <= pend_id_r;
         end
      end
   end

   // Route read data to its owner: same cycle for async uram, else from the tag
   always_comb begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      if (READ_DELAY == 0) begin
         m0_rvalid = grant_s & ~win_we_s & (winner_s == M0);
         m1_rvalid = grant_s & ~win_we_s & (winner_s == M1);
      end else begin
         m0_rvalid = pend_v_r & (pend_id_r == M0);
         m1_rvalid = pend_v_r & (pend_id_r == M1);
      end
      m0_rdata = m0_rvalid ? ram_rdata : 32'd0;
      m1_rdata = m1_rvalid ? ram_rdata : 32'd0;
   end

endmodule

// File: tb/tb_uram_arbiter.sv
// Bench for uram_arbiter: three configurations share the stimulus and are
// checked every cycle against a behavioural arbitration/memory model.
module tb_uram_arbiter;

   localparam int NI = 3;   // 0: RD=1 RR, 1: RD=1 fixed, 2: RD=0 RR

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_clr = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
   logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
   logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;

   logic        m0_gnt [NI], m1_gnt [NI], m0_rvalid [NI], m1_rvalid [NI];
   logic        ram_cs [NI], ram_we [NI];
   logic [31:0] m0_rdata [NI], m1_rdata [NI], ram_addr [NI], ram_wdata [NI], ram_rdata [NI];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic int cfg_rd(input int i);
      return (i == 2) ? 0 : 1;
   endfunction

   function automatic int cfg_pf(input int i);
      return (i == 1) ? 1 : 0;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RD = (g == 2) ? 0 : 1;
      localparam int PF = (g == 1) ? 1 : 0;
      logic [31:0] mem [64];
      logic [31:0] rd_q;

      uram_arbiter #(.READ_DELAY(RD), .PRIO_FIXED(PF)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
         .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
         .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
         .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
         .ram_cs(ram_cs[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
         .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
      );

      // uram stand-in: 64 words, async or registered read
      always @(posedge clk) begin
         if (mem_clr) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
            rd_q <= 32'd0;
         end else begin
            if (ram_cs[g] && ram_we[g])  mem[ram_addr[g][7:2]] <= ram_wdata[g];
            if (ram_cs[g] && !ram_we[g]) rd_q <= mem[ram_addr[g][7:2]];
         end
      end
      assign ram_rdata[g] = (RD == 0) ? mem[ram_addr[g][7:2]] : rd_q;
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d: actual %h required %h", nm, i, act, exp);
      end
   endtask

   // Behavioural model: lock owner, last winner, pending read, memory image
   int          own [NI], rrl [NI], pend [NI];
   logic [31:0] pend_d [NI];
   logic [31:0] mmem [NI][64];
   int          n_own [NI], n_rrl [NI], n_pend [NI];
   logic [31:0] n_pend_d [NI];
   bit          n_wr [NI];
   logic [5:0]  n_wa [NI];
   logic [31:0] n_wd [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         own[i] = -1; rrl[i] = 1; pend[i] = -1; pend_d[i] = 32'd0;
         n_own[i] = -1; n_rrl[i] = 1; n_pend[i] = -1; n_pend_d[i] = 32'd0;
         n_wr[i] = 1'b0; n_wa[i] = 6'd0; n_wd[i] = 32'd0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NI; i++) begin
         if (mem_clr) for (int k = 0; k < 64; k++) mmem[i][k] <= 32'd0;
         if (!rst_n) begin
            own[i] <= -1; rrl[i] <= 1; pend[i] <= -1;
         end else begin
            own[i] <= n_own[i]; rrl[i] <= n_rrl[i]; pend[i] <= n_pend[i]; pend_d[i] <= n_pend_d[i];
            if (n_wr[i] && !mem_clr) mmem[i][n_wa[i]] <= n_wd[i];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int          w;
         logic        e0, e1, wwe, wlk, xv0, xv1;
         logic [31:0] wa, wd, rdd, xr0, xr1;
         e0 = rst_n && m0_req && (own[i] != 1);
         e1 = rst_n && m1_req && (own[i] != 0);
         if (e0 && e1)  w = (cfg_pf(i) == 1) ? 0 : ((rrl[i] == 0) ? 1 : 0);
         else if (e0)   w = 0;
         else if (e1)   w = 1;
         else           w = -1;
         wwe = (w == 1) ? m1_we    : m0_we;
         wlk = (w == 1) ? m1_lock  : m0_lock;
         wa  = (w == 1) ? m1_addr  : m0_addr;
         wd  = (w == 1) ? m1_wdata : m0_wdata;
         rdd = mmem[i][wa[7:2]];
         if (cfg_rd(i) == 0) begin
            xv0 = (w == 0) && !wwe;
            xv1 = (w == 1) && !wwe;
            xr0 = xv0 ? rdd : 32'd0;
            xr1 = xv1 ? rdd : 32'd0;
         end else begin
            xv0 = rst_n && (pend[i] == 0);
            xv1 = rst_n && (pend[i] == 1);
            xr0 = xv0 ? pend_d[i] : 32'd0;
            xr1 = xv1 ? pend_d[i] : 32'd0;
         end
         if (chk_en) begin
            chk("m0_gnt", i, 32'(m0_gnt[i]), 32'(w == 0));
            chk("m1_gnt", i, 32'(m1_gnt[i]), 32'(w == 1));
            chk("ram_cs", i, 32'(ram_cs[i]), 32'(w >= 0));
            chk("ram_we", i, 32'(ram_we[i]), 32'((w >= 0) && wwe));
            chk("ram_addr", i, ram_addr[i], (w >= 0) ? wa : 32'd0);
            chk("ram_wdata", i, ram_wdata[i], (w >= 0) ? wd : 32'd0);
            chk("m0_rvalid", i, 32'(m0_rvalid[i]), 32'(xv0));
            chk("m1_rvalid", i, 32'(m1_rvalid[i]), 32'(xv1));
            chk("m0_rdata", i, m0_rdata[i], xr0);
            chk("m1_rdata", i, m1_rdata[i], xr1);
         end
         if (!rst_n) begin
            n_own[i] = -1; n_rrl[i] = 1; n_pend[i] = -1; n_wr[i] = 1'b0;
         end else begin
            n_rrl[i] = (w >= 0) ? w : rrl[i];
            if (own[i] == -1)     n_own[i] = ((w >= 0) && wlk) ? w : -1;
            else if (own[i] == 0) n_own[i] = m0_lock ? 0 : -1;
            else                  n_own[i] = m1_lock ? 1 : -1;
            n_pend[i]   = ((cfg_rd(i) == 1) && (w >= 0) && !wwe) ? w : -1;
            n_pend_d[i] = rdd;
            n_wr[i]     = (w >= 0) && wwe;
            n_wa[i]     = wa[7:2];
            n_wd[i]     = wd;
         end
      end
   end

   // c = {req, we, lock}
   task automatic drive(input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] d1);
      {m0_req, m0_we, m0_lock} = c0; m0_addr = a0; m0_wdata = d0;
      {m1_req, m1_we, m1_lock} = c1; m1_addr = a1; m1_wdata = d1;
   endtask

   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   task automatic to_check();
      @(negedge clk); #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      drive(3'b100, 32'h10, 32'd0, 3'b100, 32'h4, 32'd0);
      next_cyc();
      to_check();
      chk("rst_m0_gnt", 0, 32'(m0_gnt[0]), 32'd0);
      chk("rst_m1_gnt", 0, 32'(m1_gnt[0]), 32'd0);
      chk("rst_ram_cs", 0, 32'(ram_cs[0]), 32'd0);

      next_cyc(); rst_n = 1'b1; mem_clr = 1'b0;
      drive(3'b110, 32'h10, 32'hDEADBEEF, 3'b000, 32'd0, 32'd0);
      to_check();
      chk("wr_m0_gnt", 0, 32'(m0_gnt[0]), 32'd1);
      next_cyc(); drive(3'b000, 32'd0, 32'd0, 3'b110, 32'h4, 32'hA5A5A5A5);
      to_check();
      next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b000, 32'd0, 32'd0);
      to_check();
      chk("t1_m0_gnt", 0, 32'(m0_gnt[0]), 32'd1);
      chk("t1_m0_rvalid_early", 0, 32'(m0_rvalid[0]), 32'd0);
      chk("t1_rd0_rdata", 2, m0_rdata[2], 32'hDEADBEEF);
      next_cyc(); drive(3'b000, 32'd0, 32'd0, 3'b100, 32'h4, 32'd0);
      to_check();
      chk("t1_m0_rvalid", 0, 32'(m0_rvalid[0]), 32'd1);
      chk("t1_m0_rdata", 0, m0_rdata[0], 32'hDEADBEEF);
      chk("t1_m1_rvalid", 0, 32'(m1_rvalid[0]), 32'd0);
      chk("t7_m1_gnt", 2, 32'(m1_gnt[2]), 32'd1);
      chk("t7_m1_rvalid", 2, 32'(m1_rvalid[2]), 32'd1);
      chk("t7_m1_rdata", 2, m1_rdata[2], 32'hA5A5A5A5);

      for (int k = 0; k < 4; k++) begin
         next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b100, 32'h4, 32'd0);
         to_check();
         chk("t2_m0_gnt", 0, 32'(m0_gnt[0]), 32'(k % 2 == 0));
         chk("t2_m1_gnt", 0, 32'(m1_gnt[0]), 32'(k % 2 == 1));
         chk("t3_m0_gnt", 1, 32'(m0_gnt[1]), 32'd1);
         if (k > 0) begin
            chk("t2_m0_rdata", 0, m0_rdata[0], (k % 2 == 1) ? 32'hDEADBEEF : 32'd0);
            chk("t2_m1_rdata", 0, m1_rdata[0], (k % 2 == 0) ? 32'hA5A5A5A5 : 32'd0);
         end
      end
      next_cyc(); drive(3'b000, 32'd0, 32'd0, 3'b100, 32'h4, 32'd0);
      to_check();
      chk("t3_m1_gnt", 1, 32'(m1_gnt[1]), 32'd1);

      next_cyc(); drive(3'b000, 32'd0, 32'd0, 3'b111, 32'h20, 32'h12345678);
      to_check();
      chk("t4_wr_gnt", 0, 32'(m1_gnt[0]), 32'd1);
      next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b100, 32'h20, 32'd0);
      to_check();
      chk("t4_m1_gnt", 1, 32'(m1_gnt[1]), 32'd1);
      chk("t4_m0_gnt", 1, 32'(m0_gnt[1]), 32'd0);
      chk("t4_rd0_rdata", 2, m1_rdata[2], 32'h12345678);
      next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b000, 32'd0, 32'd0);
      to_check();
      chk("t4_m0_next", 0, 32'(m0_gnt[0]), 32'd1);
      chk("t4_m1_rdata", 0, m1_rdata[0], 32'h12345678);

      next_cyc(); drive(3'b101, 32'h10, 32'd0, 3'b000, 32'd0, 32'd0);
      to_check();
      chk("t5_lock_gnt", 0, 32'(m0_gnt[0]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         next_cyc(); drive(3'b001, 32'h10, 32'd0, 3'b100, 32'h4, 32'd0);
         to_check();
         chk("t5_m1_stall", 1, 32'(m1_gnt[1]), 32'd0);
      end
      next_cyc(); drive(3'b000, 32'h10, 32'd0, 3'b100, 32'h4, 32'd0);
      to_check();
      chk("t5_m1_unlock_cyc", 0, 32'(m1_gnt[0]), 32'd0);
      next_cyc();
      to_check();
      chk("t5_m1_gnt", 0, 32'(m1_gnt[0]), 32'd1);

      next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b000, 32'd0, 32'd0);
      to_check();
      chk("t6_m0_gnt", 0, 32'(m0_gnt[0]), 32'd1);
      rst_n = 1'b0;
      next_cyc(); drive(3'b100, 32'h10, 32'd0, 3'b100, 32'h4, 32'd0);
      to_check();
      chk("t6_rst_gnt", 0, 32'(m0_gnt[0] | m1_gnt[0]), 32'd0);
      chk("t6_rst_rvalid", 0, 32'(m0_rvalid[0]), 32'd0);
      next_cyc(); rst_n = 1'b1;
      to_check();
      chk("t6_tie_m0", 0, 32'(m0_gnt[0]), 32'd1);
      chk("t6_no_rvalid", 0, 32'(m0_rvalid[0] | m1_rvalid[0]), 32'd0);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] r;
         next_cyc();
         r = $urandom;
         drive({r[0], r[1], (r[5:4] == 2'b00)}, {24'd0, r[11:6], 2'b00}, $urandom,
               {r[2], r[3], (r[13:12] == 2'b00)}, {24'd0, r[19:14], 2'b00}, $urandom);
         if ($urandom_range(399, 0) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      to_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
